imem_responder: RTL and testbench
=================================

# imem_responder

Instruction-memory responder on the fetch side of the NPC core. It accepts one fetch request at a time over a valid/ready request channel. After a fixed, parameterised latency it returns the 32-bit instruction word over a valid/ready response channel. It replaces the zero-latency combinational fetch path, so the core's fetch stage can be developed against a realistic, stalling memory. A write port lets the simulation loader (or a later store path) fill the array.

## Interface
- ADDR_WIDTH, 64, fetch/write address width (matches the core PC width)
- INST_WIDTH, 32, instruction word width
- DEPTH_WORDS, 4096, number of 32-bit words in the array
- BASE_ADDR, 64'h8000_0000, byte address of word 0 (equals the core PC reset value)
- LATENCY, 2, request-accept to response-valid distance in cycles; legal range 1..15
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  core presents a fetch request
- req_addr  in  ADDR_WIDTH  byte address of the instruction
- req_ready  out  1  responder can accept a request
- resp_valid  out  1  response word available
- resp_inst  out  INST_WIDTH  fetched instruction (0 when resp_err)
- resp_err  out  1  request was misaligned or out of range
- resp_ready  in  1  core consumes the response
- wr_en  in  1  write one word into the array
- wr_addr  in  ADDR_WIDTH  byte address of the write
- wr_data  in  INST_WIDTH  word to write

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: req_ready=1, resp_valid=0. On req_valid && req_ready:
  - latch req_addr;
  - compute err = (addr[1:0]!=0) || (addr < BASE_ADDR) || ((addr-BASE_ADDR)>>2 >= DEPTH_WORDS);
  - load cnt = LATENCY-1;
  - go to WAIT.
- WAIT: req_ready=0.
  - If cnt==0: register resp_inst = err ? 0 : mem[(addr-BASE_ADDR)>>2], register resp_err = err, and go to RESP.
  - Otherwise decrement cnt.
- RESP: resp_valid=1, resp_inst and resp_err held stable. On resp_ready, go to IDLE. Without resp_ready, stay in RESP indefinitely; outputs do not change.
- Exactly one outstanding request. req_addr is ignored outside IDLE.
- Write port operates in any state:
  - mem[(wr_addr-BASE_ADDR)>>2] <= wr_data when wr_en is set and the address is aligned and in range;
  - otherwise the write is silently dropped.
- Read/write collision: the read samples the array before the same-edge write, so the old word is returned. A write landing in an earlier WAIT cycle is visible.
- Array contents are not reset.
- Reset (async, any state): state=IDLE, cnt=0, resp_valid=0, resp_inst=0, resp_err=0, req_ready=1 once rst deasserts. Any in-flight request is dropped with no response.

## Timing
- Request handshake at edge k gives resp_valid=1 from edge k+LATENCY onward.
- Response handshake at edge m gives state IDLE after m. req_ready is high in the cycle following m. The next request is accepted at edge m+1 at the earliest.
- Best-case throughput: one fetch per LATENCY+2 cycles.
- req_ready and resp_valid are registered state decodes. No combinational path from req_valid or resp_ready to any output.
- Address arithmetic is done in ADDR_WIDTH bits. The out-of-range check uses the full subtraction result, not a truncated index, so addresses that wrap below BASE_ADDR are flagged as errors.

## Structure
- Package imem_pkg holds:
  - the state enum (IDLE/WAIT/RESP);
  - the BASE_ADDR default constant, shared with the PC reset value;
  - a localparam helper for the index width, $clog2(DEPTH_WORDS).
- Sub-module imem_array: DEPTH_WORDS x INST_WIDTH storage with one synchronous write port and one read port (read-before-write on same edge), no reset.
- FSM, latency counter and range check live in imem_responder.

## Test plan
- Reset, then preload word 0 = 32'h0010_0093. Request 0x8000_0000 with LATENCY=2 and resp_ready=1 → resp_valid rises exactly 2 edges after accept, resp_inst=32'h0010_0093, resp_err=0, req_ready returns 1 the cycle after the response.
- Request 0x8000_0002 → after LATENCY, resp_err=1 and resp_inst=0. Request 0x7FFF_FFFC, then BASE_ADDR+4*DEPTH_WORDS → both give resp_err=1.
- Hold resp_ready=0 for 10 cycles after resp_valid → resp_valid and resp_inst stay stable, req_ready=0, a new req_valid is ignored. Releasing resp_ready completes exactly one response.
- Write 32'hDEAD_BEEF to the requested word in the WAIT cycle with cnt=1 → new data returned. Repeat with the write on the cnt==0 edge → old data returned.
- Assert rst asynchronously mid-WAIT → resp_valid=0 and state IDLE immediately, no response is ever produced for that request, array contents are preserved on the next fetch.
- Back-to-back fetches of 0x8000_0000, 0x8000_0004, 0x8000_0008 with req_valid held and resp_ready=1 → accepts spaced exactly LATENCY+2 cycles apart, words returned in order.

Source files
------------

// File: rtl/imem_pkg.sv
// imem_pkg: types and constants shared by the instruction-memory responder.
//   state_t           responder FSM states (IDLE / WAIT / RESP)
//   BASE_ADDR_DEFAULT byte address of word 0; equals the core PC reset value
//   idx_width()       word-index width for a given array depth
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [63:0] BASE_ADDR_DEFAULT = 64'h8000_0000;

  // Latency counter width; covers LATENCY-1 for LATENCY up to 15.
  localparam int CNT_W = 4;

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/imem_array.sv
// imem_array: DEPTH_WORDS x INST_WIDTH instruction storage, no reset.
//   clk      clock
//   we       write enable (caller has already range-checked the address)
//   wr_idx   word index of the write
//   wr_data  word to write
//   rd_idx   word index of the read
//   rd_data  current contents at rd_idx (asynchronous read)
// The read is combinational, so a consumer that registers rd_data on the same
// edge as a write to that word captures the old contents (read-before-write).
module imem_array
  import imem_pkg::*;
#(
  parameter int INST_WIDTH  = 32,
  parameter int DEPTH_WORDS = 4096,
  parameter int IDX_W       = idx_width(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [INST_WIDTH-1:0] wr_data,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [INST_WIDTH-1:0] rd_data
);

  logic [INST_WIDTH-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/imem_responder.sv
// imem_responder: fixed-latency instruction fetch responder.
//   clk, rst     clock; asynchronous active-high reset
//   req_valid    fetch request present
//   req_addr     byte address of the instruction
//   req_ready    high while idle (one outstanding request at most)
//   resp_valid   response word available; held until resp_ready
//   resp_inst    fetched word, 0 on error
//   resp_err     request was misaligned or outside the array
//   resp_ready   core consumes the response
//   wr_en        write one word (any state); bad addresses are dropped
//   wr_addr      byte address of the write
//   wr_data      word to write
// A request accepted at edge k produces resp_valid from edge k+LATENCY.
module imem_responder
  import imem_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 64,
  parameter int                    INST_WIDTH  = 32,
  parameter int                    DEPTH_WORDS = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(BASE_ADDR_DEFAULT),
  parameter int                    LATENCY     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic [INST_WIDTH-1:0] resp_inst,
  output logic                  resp_err,
  input  logic                  resp_ready,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [INST_WIDTH-1:0] wr_data
);

  localparam int IDX_W = idx_width(DEPTH_WORDS);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("imem_responder: LATENCY must be in 1..15");
  end

  // Misaligned, below the base, or beyond the array. The range test uses
  // the full-width offset so addresses that wrap below BASE_ADDR are caught.
  function automatic logic addr_bad(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return ((a & ADDR_WIDTH'(3)) != '0) ||
           (a < BASE_ADDR) ||
           ((off >> 2) >= ADDR_WIDTH'(DEPTH_WORDS));
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return IDX_W'(off >> 2);
  endfunction

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             accept;
  logic             capture;

  logic [IDX_W-1:0]      idx_q;
  logic                  err_q;
  logic                  req_bad;
  logic [IDX_W-1:0]      req_idx;
  logic                  wr_ok;
  logic [IDX_W-1:0]      wr_idx;
  logic [INST_WIDTH-1:0] rd_data;

  assign req_bad = addr_bad(req_addr);
  assign req_idx = addr_idx(req_addr);
  assign wr_ok   = wr_en && !addr_bad(wr_addr);
  assign wr_idx  = addr_idx(wr_addr);

  imem_array #(
    .INST_WIDTH  (INST_WIDTH),
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk     (clk),
    .we      (wr_ok),
    .wr_idx  (wr_idx),
    .wr_data (wr_data),
    .rd_idx  (idx_q),
    .rd_data (rd_data)
  );

  // Handshake outputs are pure state decodes: no input-to-output paths.
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    capture    = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          accept     = 1'b1;
          cnt_next   = CNT_W'(LATENCY - 1);
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          capture    = 1'b1;
          state_next = RESP;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Control state and the response registers (which must read 0 out of reset).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      resp_inst <= '0;
      resp_err  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (capture) begin
        resp_inst <= err_q ? '0 : rd_data;
        resp_err  <= err_q;
      end
    end
  end

  // Request capture: the index and error flag are only consumed after an
  // accept, so they need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q <= req_idx;
      err_q <= req_bad;
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
module tb_imem_responder;
  localparam int          LAT   = 2;
  localparam int          DEPTH = 4096;
  localparam logic [63:0] BASE  = 64'h8000_0000;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic [63:0] req_addr;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_inst;
  logic        resp_err;
  logic        resp_ready;
  logic        wr_en;
  logic [63:0] wr_addr;
  logic [31:0] wr_data;

  imem_responder dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_inst  (resp_inst),
    .resp_err   (resp_err),
    .resp_ready (resp_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference memory image, indexed by word number.
  logic [31:0] mdl [DEPTH];

  typedef struct packed {
    logic [63:0] addr;
    logic [31:0] inst;
    logic        err;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Fetch legality from plain arithmetic on the byte address.
  function automatic bit tb_err(input logic [63:0] a);
    if (a % 4 != 0) return 1'b1;
    if (a < BASE) return 1'b1;
    if ((a - BASE) / 4 >= DEPTH) return 1'b1;
    return 1'b0;
  endfunction

  task automatic write_word(input logic [63:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
    if (!tb_err(a)) mdl[(a - BASE) / 4] = d;
  endtask

  // One full transaction. wr_cyc: -1 no write, 0 write lands on the edge
  // after accept (cnt=1), 1 write lands on the capture edge (cnt=0).
  // hold: cycles resp_ready stays low after resp_valid rises.
  task automatic fetch(input logic [63:0] a, input int wr_cyc, input logic [63:0] wa,
                       input logic [31:0] wd, input int hold,
                       input logic [31:0] exp_inst, input logic exp_err, input string name);
    int n;
    int lat;
    logic [31:0] held;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check({name, "_ready_timeout"}, 64'(n < 20), 64'd1);
    req_valid  = 1'b1;
    req_addr   = a;
    resp_ready = (hold == 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = {$urandom, $urandom};
    check({name, "_busy"}, req_ready, 1'b0);
    lat = 0;
    while (!resp_valid && lat < 20) begin
      if (lat == wr_cyc) begin
        wr_en = 1'b1; wr_addr = wa; wr_data = wd;
      end
      @(posedge clk); #1;
      wr_en = 1'b0;
      lat++;
    end
    check({name, "_latency"}, lat, LAT);
    check({name, "_inst"}, resp_inst, exp_inst);
    check({name, "_err"}, resp_err, exp_err);
    held = resp_inst;
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1;
      req_addr  = BASE + 64'd4;
      @(posedge clk); #1;
      check({name, "_hold_valid"}, resp_valid, 1'b1);
      check({name, "_hold_inst"}, resp_inst, held);
      check({name, "_hold_ready"}, req_ready, 1'b0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    check({name, "_done_valid"}, resp_valid, 1'b0);
    check({name, "_done_ready"}, req_ready, 1'b1);
  endtask

  initial begin
    int          cyc;
    int          nacc;
    int          nrsp;
    int          acc_t [3];
    logic [31:0] rsp [3];
    bit          a_now;
    bit          r_now;
    logic [63:0] addr;
    logic [63:0] wa;
    logic [31:0] wd;
    int          wc;
    int          hold;
    int          k;
    logic        e;
    logic [31:0] ei;

    rst = 1'b1; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_inst", resp_inst, 32'h0);
    check("rst_resp_err", resp_err, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_req_ready", req_ready, 1'b1);

    // Preload a small region plus the last word.
    write_word(BASE, 32'h0010_0093);
    write_word(BASE + 4, 32'h0020_0113);
    write_word(BASE + 8, 32'h0030_0193);
    for (int i = 3; i < 16; i++) write_word(BASE + 64'(4 * i), $urandom);
    write_word(BASE + 64'h3FFC, 32'hCAFE_F00D);

    vecs[0] = '{64'h8000_0000, 32'h0010_0093, 1'b0};
    vecs[1] = '{64'h8000_0004, 32'h0020_0113, 1'b0};
    vecs[2] = '{64'h8000_0008, 32'h0030_0193, 1'b0};
    vecs[3] = '{64'h8000_0002, 32'h0, 1'b1};
    vecs[4] = '{64'h7FFF_FFFC, 32'h0, 1'b1};
    vecs[5] = '{64'h8000_4000, 32'h0, 1'b1};
    vecs[6] = '{64'h8000_3FFC, 32'hCAFE_F00D, 1'b0};
    vecs[7] = '{64'h0000_0000, 32'h0, 1'b1};
    vecs[8] = '{64'hFFFF_FFFF_8000_0000, 32'h0, 1'b1};
    vecs[9] = '{64'h8000_0001, 32'h0, 1'b1};
    for (int i = 0; i < 10; i++)
      fetch(vecs[i].addr, -1, '0, '0, 0, vecs[i].inst, vecs[i].err, $sformatf("vec%0d", i));

    // Dropped writes: misaligned and just past the array must not alias.
    write_word(BASE + 6, 32'h1111_1111);
    write_word(BASE + 64'h4000, 32'h2222_2222);
    fetch(BASE + 4, -1, '0, '0, 0, 32'h0020_0113, 1'b0, "drop_misaligned");
    fetch(BASE, -1, '0, '0, 0, 32'h0010_0093, 1'b0, "drop_range");

    // Stalled response with a competing request presented.
    fetch(BASE, -1, '0, '0, 10, 32'h0010_0093, 1'b0, "stall");

    // Write collisions: visible in the cnt=1 cycle, old data on the capture edge.
    fetch(BASE + 16, 0, BASE + 16, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 1'b0, "wr_early");
    mdl[4] = 32'hDEAD_BEEF;
    fetch(BASE + 20, 1, BASE + 20, 32'hDEAD_BEEF, 0, mdl[5], 1'b0, "wr_late");
    mdl[5] = 32'hDEAD_BEEF;
    fetch(BASE + 20, -1, '0, '0, 0, 32'hDEAD_BEEF, 1'b0, "wr_late_after");

    // Asynchronous reset in the middle of WAIT.
    req_valid = 1'b1; req_addr = BASE; resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("arst_accepted", req_ready, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("arst_resp_valid", resp_valid, 1'b0);
    check("arst_req_ready", req_ready, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    k = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (resp_valid) k++;
    end
    check("arst_no_resp", k, 0);
    fetch(BASE, -1, '0, '0, 0, 32'h0010_0093, 1'b0, "arst_mem_kept");

    // Back-to-back with req_valid held.
    cyc = 0; nacc = 0; nrsp = 0;
    req_valid = 1'b1; req_addr = BASE; resp_ready = 1'b1;
    while ((nacc < 3 || nrsp < 3) && cyc < 60) begin
      a_now = req_valid && req_ready;
      r_now = resp_valid && resp_ready;
      if (r_now && nrsp < 3) begin
        rsp[nrsp] = resp_inst;
        nrsp++;
      end
      @(posedge clk); #1;
      cyc++;
      if (a_now) begin
        acc_t[nacc] = cyc;
        nacc++;
        if (nacc < 3) req_addr = BASE + 64'(4 * nacc);
        else req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    check("b2b_accepts", nacc, 3);
    check("b2b_responses", nrsp, 3);
    if (nacc == 3) begin
      check("b2b_gap0", acc_t[1] - acc_t[0], LAT + 2);
      check("b2b_gap1", acc_t[2] - acc_t[1], LAT + 2);
    end
    for (int i = 0; i < nrsp; i++) check($sformatf("b2b_word%0d", i), rsp[i], mdl[i]);

    // Randomized transactions against the memory image.
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 9);
      if (k < 7)       addr = BASE + 64'(4 * $urandom_range(0, 15));
      else if (k == 7) addr = BASE + 64'(4 * $urandom_range(0, 15)) + 64'($urandom_range(1, 3));
      else if (k == 8) addr = BASE - 64'(4 * $urandom_range(1, 1000));
      else             addr = BASE + 64'(4 * (DEPTH + $urandom_range(0, 1000)));
      wc   = int'($urandom_range(0, 2)) - 1;
      wa   = BASE + 64'(4 * $urandom_range(0, 15));
      wd   = $urandom;
      hold = $urandom_range(0, 3);
      e    = tb_err(addr);
      if (e) ei = 32'h0;
      else if (wc == 0 && wa == addr) ei = wd;
      else ei = mdl[(addr - BASE) / 4];
      fetch(addr, wc, wa, wd, hold, ei, e, $sformatf("rnd%0d", i));
      if (wc >= 0) mdl[(wa - BASE) / 4] = wd;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
